// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic is_store(input op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] access_size(input op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
      default:              return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Big-endian lane handling: extract/extend for loads, lane merge for sub-word stores.
module lane_align
  import lsu_pkg::*;
(
  input  op_t         op,
  input  logic [1:0]  offset,
  input  logic [31:0] readWord,
  input  logic [15:0] storeLow,
  output logic [31:0] loadValue,
  output logic [31:0] mergedWord
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Pick the addressed lane, extend it for loads and splice the store lane into the read word
  always_comb begin
    byteLane   = 8'h00;
    halfLane   = 16'h0000;
    loadValue  = readWord;
    mergedWord = readWord;

    case (offset)
      2'd0:    byteLane = readWord[31:24];
      2'd1:    byteLane = readWord[23:16];
      2'd2:    byteLane = readWord[15:8];
      default: byteLane = readWord[7:0];
    endcase
    halfLane = offset[1] ? readWord[15:0] : readWord[31:16];

    case (op)
      OP_LB:   loadValue = {{24{byteLane[7]}}, byteLane};
      OP_LBU:  loadValue = {24'h000000, byteLane};
      OP_LH:   loadValue = {{16{halfLane[15]}}, halfLane};
      OP_LHU:  loadValue = {16'h0000, halfLane};
      default: loadValue = readWord;
    endcase

    case (op)
      OP_SB: begin
        case (offset)
          2'd0:    mergedWord[31:24] = storeLow[7:0];
          2'd1:    mergedWord[23:16] = storeLow[7:0];
          2'd2:    mergedWord[15:8]  = storeLow[7:0];
          default: mergedWord[7:0]   = storeLow[7:0];
        endcase
      end
      OP_SH: begin
        if (offset[1]) mergedWord[15:0] = storeLow;
        else           mergedWord[31:16] = storeLow;
      end
      default: mergedWord = readWord;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: validates a request, then runs READ and/or WRITE against word memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DMSize = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [31:0] LoadData,
  output logic        MemoryRead,
  output logic        MemoryWrite,
  output logic [31:0] Address,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData
);

  localparam logic [31:0] LastWord = 32'(DMSize - 4);

  state_t      state, nextState;
  logic        errPending, nextErrPending;
  logic        accept;
  logic        reqError;
  op_t         reqOp;
  op_t         opReg;
  logic [1:0]  offsetReg;
  logic [15:0] storeLow;
  logic [31:0] wordAddr;
  logic [31:0] loadValue;
  logic [31:0] mergedWord;

  assign reqOp    = op_t'(Op);
  assign wordAddr = {Addr[31:2], 2'b00};

  // Reject misaligned requests and any word beyond the end of memory
  always_comb begin
    reqError = 1'b0;
    case (access_size(reqOp))
      SIZE_WORD: reqError = (Addr[1:0] != 2'b00);
      SIZE_HALF: reqError = Addr[0];
      default:   reqError = 1'b0;
    endcase
    if (wordAddr > LastWord) reqError = 1'b1;
  end

  // Next-state decode; a rejected request stays idle and reports one cycle later
  always_comb begin
    nextState      = state;
    nextErrPending = 1'b0;
    accept         = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (reqError) begin
            nextErrPending = 1'b1;
          end else begin
            accept    = 1'b1;
            nextState = (reqOp == OP_SW) ? WRITE : READ;
          end
        end
      end
      READ:    nextState = is_store(opReg) ? WRITE : IDLE;
      WRITE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register and pending-error flag
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      errPending <= 1'b0;
    end else begin
      state      <= nextState;
      errPending <= nextErrPending;
    end
  end

  // Request latches, memory-side registers, load result and completion pulse
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      opReg        <= OP_LB;
      offsetReg    <= 2'b00;
      storeLow     <= 16'h0000;
      Address      <= 32'h0;
      MemWriteData <= 32'h0;
      LoadData     <= 32'h0;
      Done         <= 1'b0;
      Error        <= 1'b0;
    end else begin
      Done  <= errPending || (state == WRITE) || ((state == READ) && !is_store(opReg));
      Error <= errPending;
      if (accept) begin
        opReg     <= reqOp;
        offsetReg <= Addr[1:0];
        storeLow  <= StoreData[15:0];
        Address   <= wordAddr;
        if (reqOp == OP_SW) MemWriteData <= StoreData;
      end
      if (state == READ) begin
        if (is_store(opReg)) MemWriteData <= mergedWord;
        else                 LoadData     <= loadValue;
      end
    end
  end

  assign Busy        = (state != IDLE);
  assign MemoryRead  = (state == READ);
  assign MemoryWrite = (state == WRITE);

  lane_align u_laneAlign (
    .op        (opReg),
    .offset    (offsetReg),
    .readWord  (MemReadData),
    .storeLow  (storeLow),
    .loadValue (loadValue),
    .mergedWord(mergedWord)
  );

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator for the MIPS datapath. Accepts one load or store request at a time from the pipeline. Drives the word-wide, big-endian data memory, whose read path is combinational and whose write happens at the posedge. Implements LB/LBU/LH/LHU/LW and SB/SH/SW on top of a memory that only moves whole 4-byte words. Sub-word stores use read-modify-write; loads get byte-lane extraction and sign/zero extension; misaligned and out-of-range accesses are rejected.

## Interface
Parameters:
- DMSize, 1024, memory size in bytes; legal word addresses are 0 .. DMSize-4.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- Start  in  1  request strobe; sampled only in IDLE.
- Op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW.
- Addr  in  32  byte address of the access.
- StoreData  in  32  store operand; the low byte or halfword is used for SB/SH.
- Busy  out  1  high whenever the state is not IDLE.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  valid with Done; request was rejected and no memory write occurred.
- LoadData  out  32  extended load result; updated only on a successful load.
- MemoryRead  out  1  to the memory read enable.
- MemoryWrite  out  1  to the memory write enable.
- Address  out  32  to the memory; always word-aligned (Addr & ~3).
- MemWriteData  out  32  to the memory input data.
- MemReadData  in  32  from the memory output data.

## Operation
- States: IDLE, READ, WRITE.
- Byte order is big-endian. Byte offset k = Addr[1:0] maps to bits [31-8k : 24-8k]. Halfword offset 0 maps to [31:16]; offset 2 maps to [15:0].
- IDLE with Start=1: latch Op, Addr & ~3, StoreData, and the offset.
  - Error check first:
    - LW/SW require Addr[1:0]=0.
    - LH/LHU/SH require Addr[0]=0.
    - Every op requires (Addr & ~3) <= DMSize-4.
  - On an error, stay in IDLE and pulse Done=1, Error=1 next cycle. No MemoryRead or MemoryWrite is asserted.
  - Loads and SB/SH go to READ.
  - SW goes to WRITE with MemWriteData=StoreData.
- READ:
  - Drive MemoryRead=1 with Address.
  - At the closing posedge, sample MemReadData.
  - Load: extract the lane, then sign-extend (LB, LH) or zero-extend (LBU, LHU); LW passes the word through. Write the result to LoadData, go to IDLE, pulse Done.
  - SB/SH: merge the StoreData low lane into the sampled word, leaving the other lanes unchanged. Load the merged word into MemWriteData and go to WRITE.
- WRITE: drive MemoryWrite=1 with Address and MemWriteData. The memory captures at the closing posedge. Go to IDLE and pulse Done.
- Start is ignored while Busy=1.
- A new Start is accepted in the same cycle Done is high, because the unit is already in IDLE then.
- MemoryRead and MemoryWrite are never high together. Both decode from the state register only, with no combinational path from Start.

## Timing
- Start sampled at edge T:
  - Error: Done at T+1.
  - Load: READ in cycle T..T+1, Done and LoadData valid from T+1.
  - SW: WRITE in T..T+1, memory updated at edge T+1, Done at T+1.
  - SB/SH: READ in T..T+1, WRITE in T+1..T+2, Done at T+2.
- Throughput: one request per 2 cycles (loads, SW) or 3 cycles (SB/SH), back-to-back.
- Reset values: state=IDLE, Busy=0, Done=0, Error=0, LoadData=0, MemoryRead=0, MemoryWrite=0, Address=0, MemWriteData=0.
- Reset during READ: no write is issued and LoadData stays unchanged apart from being forced to 0.
- Reset sampled at the closing edge of WRITE: the memory still captures at that edge. This is defined behaviour.
- Done is never emitted for an aborted request.

## Structure
- Package lsu_pkg holds:
  - Op encodings (OP_LB..OP_SW).
  - State encoding.
  - Helpers is_store(op) and access_size(op).
- Sub-module lane_align (purely combinational) contains the byte/halfword extract-and-extend for loads and the lane merge for stores. The FSM and all registers stay in load_store_unit.

## Test plan
- Memory word 0x10 = 0x11223344. SB Addr=0x11, StoreData=0x000000AA:
  - READ at 0x10, then WRITE 0x11AA3344 at 0x10.
  - Done at T+2, Error=0.
- Word 0x20 = 0x112233F4:
  - LB 0x23 gives LoadData 0xFFFFFFF4.
  - LBU 0x23 gives 0x000000F4.
  - LH 0x22 gives 0x000033F4.
  - LHU 0x20 gives 0x00001122.
- Misaligned accesses:
  - LH 0x11 gives Done=1, Error=1 at T+1; MemoryRead and MemoryWrite stay 0; LoadData keeps its previous value.
  - SW 0x22 likewise gives Error with no write.
- SW 0x40 = 0xDEADBEEF, then LW 0x40 with Start asserted in the SW Done cycle:
  - LW is accepted immediately.
  - LoadData = 0xDEADBEEF two cycles later.
- Range, DMSize=1024:
  - LW 0x3FC succeeds.
  - SW 0x400 gives Error with no MemoryWrite.
- Control corner cases:
  - Start pulsed during Busy is ignored, with exactly one Done.
  - reset_n=0 sampled while SH is in READ gives MemoryWrite never asserted, all outputs at reset values, and the memory word unchanged.
